// File: rtl/rename_cam.sv
// Rename CAM: maps architectural registers to ROB entries, with supersede on
// dispatch, commit invalidation and checkpoint save/restore of the valid vector.
module rename_cam #(
   parameter int DATA   = 5,
   parameter int DEPTH  = 32,
   parameter int WRITE  = 2,
   parameter int READ   = 4,
   parameter int COMMIT = 2,
   parameter int CKPT   = 4,
   localparam int ADDR  = $clog2(DEPTH),
   localparam int CADDR = $clog2(CKPT)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WRITE-1:0]             we,
   input  logic [WRITE-1:0][DATA-1:0]   wd,
   input  logic [WRITE-1:0][ADDR-1:0]   waddr,
   input  logic [COMMIT-1:0]            ce,
   input  logic [COMMIT-1:0][ADDR-1:0]  caddr,
   input  logic                         flush,
   input  logic                         ckpt_save,
   input  logic [CADDR-1:0]             ckpt_sid,
   input  logic                         ckpt_restore,
   input  logic [CADDR-1:0]             ckpt_rid,
   input  logic [READ-1:0]              re,
   input  logic [READ-1:0][DATA-1:0]    rd,
   output logic [READ-1:0]              match,
   output logic [READ-1:0][ADDR-1:0]    raddr
);

   logic [DATA-1:0]            tag_reg  [DEPTH];
   logic [DATA-1:0]            tag_next [DEPTH];
   logic [DEPTH-1:0]           valid_reg;
   logic [DEPTH-1:0]           valid_next;
   logic [DEPTH-1:0]           valid_upd;
   logic [DEPTH-1:0]           commit_mask;
   logic [CKPT-1:0][DEPTH-1:0] ckpt_reg;
   logic [CKPT-1:0][DEPTH-1:0] ckpt_next;

   always_comb begin
      commit_mask = '0;
      for (int j = 0; j < COMMIT; j++)
         if (ce[j]) commit_mask[caddr[j]] = 1'b1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic            wr_hit;
         logic            wr_valid;
         logic            sup;
         logic [DATA-1:0] wr_tag;

         // Highest writing port owns the entry; it stays invalid if a higher
         // port dispatches the same architectural register elsewhere.
         always_comb begin
            wr_hit   = 1'b0;
            wr_valid = 1'b0;
            sup      = 1'b0;
            wr_tag   = tag_reg[gi];
            for (int k = 0; k < WRITE; k++) begin
               if (we[k] && wd[k] == tag_reg[gi]) sup = 1'b1;
               if (we[k] && waddr[k] == ADDR'(gi)) begin
                  wr_hit   = 1'b1;
                  wr_tag   = wd[k];
                  wr_valid = 1'b1;
                  for (int m = k + 1; m < WRITE; m++)
                     if (we[m] && wd[m] == wd[k]) wr_valid = 1'b0;
               end
            end
         end

         assign valid_upd[gi] = wr_hit ? wr_valid
                                       : (valid_reg[gi] & ~sup & ~commit_mask[gi]);
         assign tag_next[gi]  = (wr_hit && !flush && !ckpt_restore) ? wr_tag : tag_reg[gi];
      end
   endgenerate

   // Checkpoint save captures the vector after restore/writes/commits settle.
   always_comb begin
      valid_next = valid_upd;
      ckpt_next  = ckpt_reg;
      if (flush) begin
         valid_next = '0;
         ckpt_next  = '0;
      end else begin
         for (int s = 0; s < CKPT; s++)
            ckpt_next[s] = ckpt_reg[s] & ~commit_mask;
         if (ckpt_restore)
            valid_next = ckpt_reg[ckpt_rid] & ~commit_mask;
         if (ckpt_save)
            ckpt_next[ckpt_sid] = valid_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int e = 0; e < DEPTH; e++) tag_reg[e] <= '0;
         valid_reg <= '0;
         ckpt_reg  <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++) tag_reg[e] <= tag_next[e];
         valid_reg <= valid_next;
         ckpt_reg  <= ckpt_next;
      end
   end

   generate
      for (gi = 0; gi < READ; gi++) begin : g_read
         logic            hit;
         logic [ADDR-1:0] idx;

         always_comb begin
            hit = 1'b0;
            idx = '0;
            for (int e = 0; e < DEPTH; e++)
               if (valid_reg[e] && tag_reg[e] == rd[gi]) begin
                  hit = 1'b1;
                  idx = ADDR'(e);
               end
         end

         assign match[gi] = re[gi] & hit;
         assign raddr[gi] = match[gi] ? idx : '0;
      end
   endgenerate

endmodule

// File: tb/tb_rename_cam.sv
// Bench for rename_cam: directed vector table, hand-written flush/reset
// sequences, then random traffic against an event-ordered reference model.
module tb_rename_cam;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [1:0]      we;
   logic [1:0][4:0] wd;
   logic [1:0][4:0] waddr;
   logic [1:0]      ce;
   logic [1:0][4:0] caddr;
   logic            flush;
   logic            ckpt_save;
   logic [1:0]      ckpt_sid;
   logic            ckpt_restore;
   logic [1:0]      ckpt_rid;
   logic [3:0]      re;
   logic [3:0][4:0] rd;
   logic [3:0]      match;
   logic [3:0][4:0] raddr;

   int errors = 0;
   int checks = 0;

   rename_cam dut (
      .clk(clk), .reset(reset),
      .we(we), .wd(wd), .waddr(waddr),
      .ce(ce), .caddr(caddr),
      .flush(flush),
      .ckpt_save(ckpt_save), .ckpt_sid(ckpt_sid),
      .ckpt_restore(ckpt_restore), .ckpt_rid(ckpt_rid),
      .re(re), .rd(rd),
      .match(match), .raddr(raddr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       we0; logic [4:0] wd0; logic [4:0] wa0;
      logic       we1; logic [4:0] wd1; logic [4:0] wa1;
      logic       ce0; logic [4:0] ca0;
      logic       sv;  logic [1:0] sid;
      logic       rs;  logic [1:0] rid;
      logic       re0; logic [4:0] rd0;
      logic       em;  logic [4:0] ea;
      string      nm;
   } vec_t;

   vec_t vecs [20];

   // reference model state
   bit [4:0] m_tag [32];
   bit       m_val [32];
   bit       m_ck  [4][32];

   task automatic idle();
      we = '0; wd = '0; waddr = '0; ce = '0; caddr = '0;
      flush = 1'b0; ckpt_save = 1'b0; ckpt_sid = '0;
      ckpt_restore = 1'b0; ckpt_rid = '0; re = '0; rd = '0;
   endtask

   task automatic chk(input string nm, input int p, input logic am, input logic [4:0] ar,
                      input logic em, input logic [4:0] er);
      checks++;
      if (am !== em || ar !== er) begin
         errors++;
         $display("FAIL %s port%0d: got match=%0b raddr=%0d, want match=%0b raddr=%0d",
                  nm, p, am, ar, em, er);
      end
   endtask

   task automatic lookup_miss(input string nm, input logic [4:0] t0, input logic [4:0] t1,
                              input logic [4:0] t2, input logic [4:0] t3);
      re = 4'hf; rd[0] = t0; rd[1] = t1; rd[2] = t2; rd[3] = t3;
      #1;
      for (int p = 0; p < 4; p++) chk(nm, p, match[p], raddr[p], 1'b0, 5'd0);
   endtask

   task automatic model_clear();
      for (int e = 0; e < 32; e++) begin
         m_tag[e] = '0; m_val[e] = 1'b0;
         for (int s = 0; s < 4; s++) m_ck[s][e] = 1'b0;
      end
   endtask

   // Each write is an ordered event: drop any mapping of that register, then
   // install the new one. Commits remove only entries not dispatched this cycle.
   task automatic model_step();
      bit nv [32];
      bit cm [32];
      bit wr [32];
      if (flush) begin
         for (int e = 0; e < 32; e++) begin
            m_val[e] = 1'b0;
            for (int s = 0; s < 4; s++) m_ck[s][e] = 1'b0;
         end
         return;
      end
      for (int e = 0; e < 32; e++) begin cm[e] = 1'b0; wr[e] = 1'b0; nv[e] = m_val[e]; end
      for (int j = 0; j < 2; j++) if (ce[j]) cm[caddr[j]] = 1'b1;
      if (ckpt_restore) begin
         for (int e = 0; e < 32; e++) nv[e] = m_ck[ckpt_rid][e] && !cm[e];
      end else begin
         for (int k = 0; k < 2; k++) if (we[k]) begin
            for (int e = 0; e < 32; e++) if (m_tag[e] == wd[k]) nv[e] = 1'b0;
            m_tag[waddr[k]] = wd[k];
            nv[waddr[k]] = 1'b1;
            wr[waddr[k]] = 1'b1;
         end
         for (int e = 0; e < 32; e++) if (cm[e] && !wr[e]) nv[e] = 1'b0;
      end
      for (int s = 0; s < 4; s++)
         for (int e = 0; e < 32; e++) if (cm[e]) m_ck[s][e] = 1'b0;
      if (ckpt_save) for (int e = 0; e < 32; e++) m_ck[ckpt_sid][e] = nv[e];
      for (int e = 0; e < 32; e++) m_val[e] = nv[e];
   endtask

   task automatic model_lookups(input int cyc);
      for (int p = 0; p < 4; p++) begin
         int cnt = 0;
         int idx = 0;
         for (int e = 0; e < 32; e++)
            if (m_val[e] && m_tag[e] == rd[p]) begin cnt++; idx = e; end
         if (!re[p] || cnt <= 1) begin
            chk($sformatf("rand%0d", cyc), p, match[p], raddr[p],
                re[p] && cnt > 0, (re[p] && cnt > 0) ? 5'(idx) : 5'd0);
         end else begin
            checks++;
            if (match[p] !== 1'b1 || !(m_val[raddr[p]] && m_tag[raddr[p]] == rd[p])) begin
               errors++;
               $display("FAIL rand%0d port%0d: got match=%0b raddr=%0d, want a hit on one of %0d entries",
                        cyc, p, match[p], raddr[p], cnt);
            end
         end
      end
   endtask

   initial begin
      idle();
      // fields: we0 wd0 wa0 we1 wd1 wa1 ce0 ca0 sv sid rs rid re rd em ea name
      vecs[0]  = '{1,3,5,  0,0,0,  0,0,  0,0, 0,0, 1,3, 0,0,  "same_cycle"};
      vecs[1]  = '{0,0,0,  0,0,0,  0,0,  0,0, 0,0, 1,3, 1,5,  "write_visible"};
      vecs[2]  = '{1,3,6,  1,3,7,  0,0,  0,0, 0,0, 1,3, 1,5,  "dual_write"};
      vecs[3]  = '{0,0,0,  0,0,0,  1,7,  0,0, 0,0, 1,3, 1,7,  "hi_port_wins"};
      vecs[4]  = '{1,3,5,  0,0,0,  0,0,  0,0, 0,0, 1,3, 0,0,  "lower_invalid"};
      vecs[5]  = '{0,0,0,  0,0,0,  0,0,  1,1, 0,0, 1,3, 1,5,  "pre_save"};
      vecs[6]  = '{1,3,9,  0,0,0,  0,0,  0,0, 0,0, 1,3, 1,5,  "save_held"};
      vecs[7]  = '{0,0,0,  0,0,0,  0,0,  0,0, 1,1, 1,3, 1,9,  "newer_map"};
      vecs[8]  = '{0,0,0,  0,0,0,  0,0,  1,2, 0,0, 1,3, 1,5,  "restored"};
      vecs[9]  = '{0,0,0,  0,0,0,  1,5,  0,0, 0,0, 1,3, 1,5,  "pre_commit"};
      vecs[10] = '{0,0,0,  0,0,0,  0,0,  0,0, 1,2, 1,3, 0,0,  "committed"};
      vecs[11] = '{1,4,10, 0,0,0,  1,10, 0,0, 0,0, 1,3, 0,0,  "ckpt_commit"};
      vecs[12] = '{0,0,0,  0,0,0,  0,0,  1,3, 0,0, 1,4, 1,10, "write_beats_commit"};
      vecs[13] = '{1,6,11, 0,0,0,  0,0,  0,0, 0,0, 1,4, 1,10, "save3"};
      vecs[14] = '{0,0,0,  0,0,0,  0,0,  1,0, 1,3, 1,6, 1,11, "pre_restore"};
      vecs[15] = '{0,0,0,  0,0,0,  0,0,  0,0, 0,0, 1,6, 0,0,  "restore_drops"};
      vecs[16] = '{1,4,12, 0,0,0,  0,0,  0,0, 0,0, 1,4, 1,10, "restore_keeps"};
      vecs[17] = '{0,0,0,  0,0,0,  0,0,  0,0, 1,0, 1,4, 1,12, "supersede4"};
      vecs[18] = '{0,0,0,  0,0,0,  0,0,  0,0, 0,0, 1,4, 1,10, "save_after_restore"};
      vecs[19] = '{0,0,0,  0,0,0,  0,0,  0,0, 0,0, 0,4, 0,0,  "re_low"};

      // reset state
      repeat (2) @(negedge clk);
      lookup_miss("in_reset", 0, 1, 3, 31);
      reset = 1'b0;
      @(negedge clk);
      lookup_miss("after_reset", 0, 0, 5, 31);
      $display("reset: match=%b", match);

      // directed table
      foreach (vecs[i]) begin
         @(negedge clk);
         idle();
         we[0] = vecs[i].we0; wd[0] = vecs[i].wd0; waddr[0] = vecs[i].wa0;
         we[1] = vecs[i].we1; wd[1] = vecs[i].wd1; waddr[1] = vecs[i].wa1;
         ce[0] = vecs[i].ce0; caddr[0] = vecs[i].ca0;
         ckpt_save = vecs[i].sv; ckpt_sid = vecs[i].sid;
         ckpt_restore = vecs[i].rs; ckpt_rid = vecs[i].rid;
         re[0] = vecs[i].re0; rd[0] = vecs[i].rd0;
         #1;
         chk(vecs[i].nm, 0, match[0], raddr[0], vecs[i].em, vecs[i].ea);
         $display("vec %0d %s: match=%0b raddr=%0d", i, vecs[i].nm, match[0], raddr[0]);
      end

      // fill all entries, snapshot into every slot, then flush with a write
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         idle();
         we = 2'b11;
         wd[0] = 5'(2*c); waddr[0] = 5'(2*c);
         wd[1] = 5'(2*c+1); waddr[1] = 5'(2*c+1);
         if (c >= 12) begin ckpt_save = 1'b1; ckpt_sid = 2'(c - 12); end
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         idle();
         re = 4'hf;
         for (int p = 0; p < 4; p++) rd[p] = 5'(4*c + p);
         #1;
         for (int p = 0; p < 4; p++) chk("filled", p, match[p], raddr[p], 1'b1, 5'(4*c + p));
         $display("filled lookup %0d: match=%b", c, match);
      end
      @(negedge clk);
      idle();
      flush = 1'b1; we[0] = 1'b1; wd[0] = 5'd4; waddr[0] = 5'd0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         idle();
         lookup_miss("flushed", 5'(4*c), 5'(4*c+1), 5'(4*c+2), 5'(4*c+3));
         $display("flushed lookup %0d: match=%b", c, match);
      end
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         idle();
         ckpt_restore = 1'b1; ckpt_rid = 2'(s);
         @(negedge clk);
         idle();
         lookup_miss("flush_restore", 5'd4, 5'd0, 5'd31, 5'(24 + s));
         $display("restore slot %0d after flush: match=%b", s, match);
      end

      // reset asserted in the middle of a write burst
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         idle();
         we[0] = 1'b1; wd[0] = 5'(c); waddr[0] = 5'(c);
      end
      @(negedge clk);
      re[0] = 1'b1; rd[0] = 5'd0;
      #1;
      chk("burst_pre", 0, match[0], raddr[0], 1'b1, 5'd0);
      we[0] = 1'b1; wd[0] = 5'd2; waddr[0] = 5'd9;
      @(posedge clk);
      #2;
      reset = 1'b1;
      re = 4'hf; rd[0] = 5'd0; rd[1] = 5'd1; rd[2] = 5'd2; rd[3] = 5'd3;
      #1;
      for (int p = 0; p < 4; p++) chk("reset_async", p, match[p], raddr[p], 1'b0, 5'd0);
      @(negedge clk);
      lookup_miss("reset_held", 0, 1, 2, 3);
      reset = 1'b0;
      we = '0;
      repeat (2) @(negedge clk);
      lookup_miss("reset_released", 0, 1, 2, 3);
      we[0] = 1'b1; wd[0] = 5'd2; waddr[0] = 5'd20;
      @(negedge clk);
      idle();
      re[0] = 1'b1; rd[0] = 5'd2;
      #1;
      chk("post_reset_write", 0, match[0], raddr[0], 1'b1, 5'd20);
      $display("reset burst: match=%0b raddr=%0d", match[0], raddr[0]);

      // random traffic against the reference model
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         idle();
         we[0] = ($urandom_range(0, 3) != 0);
         we[1] = ($urandom_range(0, 2) != 0);
         wd[0] = 5'($urandom_range(0, 7));
         wd[1] = 5'($urandom_range(0, 7));
         waddr[0] = 5'($urandom_range(0, 31));
         waddr[1] = 5'((waddr[0] + 1 + $urandom_range(0, 30)) % 32);
         ce[0] = ($urandom_range(0, 2) == 0);
         ce[1] = ($urandom_range(0, 3) == 0);
         caddr[0] = 5'($urandom_range(0, 31));
         caddr[1] = 5'($urandom_range(0, 31));
         ckpt_save = ($urandom_range(0, 7) == 0);
         ckpt_sid = 2'($urandom_range(0, 3));
         ckpt_restore = ($urandom_range(0, 15) == 0);
         ckpt_rid = 2'($urandom_range(0, 3));
         flush = ($urandom_range(0, 63) == 0);
         for (int p = 0; p < 4; p++) begin
            re[p] = ($urandom_range(0, 4) != 0);
            rd[p] = 5'($urandom_range(0, 8));
         end
         #1;
         model_lookups(c);
         $display("rand %0d: we=%b ce=%b sv=%0b rs=%0b fl=%0b match=%b",
                  c, we, ce, ckpt_save, ckpt_restore, flush, match);
         model_step();
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
